mem_access_unit: RTL and testbench

Memory access unit sitting between the control unit and program/data RAM. It muxes the address and write data from the control unit's `addr_sel`/`data_sel` selectors and runs one RAM transaction at a time with an ack handshake and timeout. It generates `memory_ready` for the control unit's sequencer and holds the instruction register that supplies `opcode`. It runs on `posedge clk`; the control unit samples on `negedge`, so every output is stable half a cycle before it is used.

---
 rtl/mem_access_unit.sv | 210 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: address/write-data muxing, one RAM transaction at a time
// with ack handshake and timeout. It also holds the instruction register
// that supplies opcode to the control unit.
// Every output comes from a flop, so it is stable well before the
// negedge sampling done by the control unit.
module mem_access_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic              cmd_w,
    input  logic [1:0]        addr_sel,
    input  logic [1:0]        data_sel,
    input  logic [ADDR_W-1:0] sr,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] r1,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] rd_data,
    output logic [5:0]        opcode,
    output logic              memory_ready,
    output logic              error
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    localparam int          MAX_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    // The last counter value before the timeout fires: ERR is entered on
    // the TIMEOUT-th edge after the request edge.
    localparam logic [7:0]  CNT_TOP = 8'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Zero-extend or truncate an address-width value onto the data bus.
    function automatic logic [DATA_W-1:0] addr_to_data(input logic [ADDR_W-1:0] a);
        logic [MAX_W-1:0] wide;
        wide = MAX_W'(a);
        return wide[DATA_W-1:0];
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] addr_mux_s;
    logic [DATA_W-1:0] data_mux_s;
    logic              req_s;

    assign req_s = req_rd | req_wr;

    // Source selection for address and write data (wraps modulo 2^ADDR_W).
    always_comb begin
        addr_mux_s = sr;
        data_mux_s = addr_to_data(sr);
        case (addr_sel)
            2'd0:    addr_mux_s = sr;
            2'd1:    addr_mux_s = sr - ADDR_ONE;
            2'd2:    addr_mux_s = pc;
            2'd3:    addr_mux_s = r1;
            default: addr_mux_s = sr;
        endcase
        case (data_sel)
            2'd0:    data_mux_s = addr_to_data(sr);
            2'd1:    data_mux_s = addr_to_data(pc + ADDR_ONE);
            2'd2:    data_mux_s = alu_out;
            2'd3:    data_mux_s = imm;
            default: data_mux_s = addr_to_data(sr);
        endcase
    end

    // Transaction sequencing, output next-state and the instruction register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        ready_d     = ready_q;
        error_d     = error_q;
        // ir always takes the word already held, so a cmd_w on a read's ack
        // cycle loads the previous word rather than the one arriving.
        if (cmd_w) begin
            ir_d = rd_data_q;
        end else begin
            ir_d = ir_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    state_d     = ST_ACCESS;
                    cnt_d       = 8'd0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = req_wr;   // write wins over a coincident read
                    mem_addr_d  = addr_mux_s;
                    mem_wdata_d = data_mux_s;
                    ready_d     = 1'b0;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (req_s) begin
                    error_d = 1'b1;
                end else begin
                    error_d = error_q;
                end
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        rd_data_d = mem_rdata;
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                    state_d  = ST_DONE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                end else if (cnt_q == CNT_TOP) begin
                    state_d  = ST_ERR;
                    error_d  = 1'b1;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                if (req_s) begin
                    error_d = 1'b1;
                end else begin
                    error_d = error_q;
                end
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            ST_ERR: begin
                if (req_s) begin
                    error_d = 1'b1;
                end else begin
                    error_d = error_q;
                end
                ready_d  = 1'b0;
                mem_en_d = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                ready_d  = 1'b1;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the RAM strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            ir_q        <= '0;
            ready_q     <= 1'b1;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            ir_q        <= ir_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
        end
    end

    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign rd_data      = rd_data_q;
    assign opcode       = ir_q[DATA_W-1 -: 6];
    assign memory_ready = ready_q;
    assign error        = error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk;
    logic          rst_n;
    logic          req_rd, req_wr, cmd_w, mem_ack;
    logic [1:0]    addr_sel, data_sel;
    logic [AW-1:0] sr, pc, r1;
    logic [DW-1:0] alu_out, imm, mem_rdata;
    logic          mem_en, mem_we, memory_ready, error;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, rd_data;
    logic [5:0]    opcode;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr),
        .cmd_w(cmd_w), .addr_sel(addr_sel), .data_sel(data_sel),
        .sr(sr), .pc(pc), .r1(r1), .alu_out(alu_out), .imm(imm),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rd_data(rd_data), .opcode(opcode), .memory_ready(memory_ready),
        .error(error)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read with ack on the first ACCESS cycle; returns in IDLE.
    task automatic quick_read(input logic [DW-1:0] data, input logic cmd_on_ack);
        addr_sel = 2'd2; req_rd = 1'b1;
        step();
        req_rd = 1'b0; mem_ack = 1'b1; mem_rdata = data; cmd_w = cmd_on_ack;
        step();
        mem_ack = 1'b0; cmd_w = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; req_rd = 1'b0; req_wr = 1'b0; cmd_w = 1'b0; mem_ack = 1'b0;
        addr_sel = 2'd0; data_sel = 2'd0; sr = 16'h0; pc = 16'h0; r1 = 16'h0;
        alu_out = 16'h0; imm = 16'h0; mem_rdata = 16'h0;
        #12;
        check("rst_ready", {31'd0, memory_ready}, 32'd1);
        check("rst_en",    {31'd0, mem_en},       32'd0);
        check("rst_opc",   {26'd0, opcode},       32'd0);
        check("rst_err",   {31'd0, error},        32'd0);
        rst_n = 1'b1;
        step();

        // Read, ack on the second ACCESS cycle.
        sr = 16'h0010; addr_sel = 2'd0; req_rd = 1'b1;
        step();
        req_rd = 1'b0;
        check("rd_ready_lo", {31'd0, memory_ready}, 32'd0);
        check("rd_en",       {31'd0, mem_en},       32'd1);
        check("rd_addr",     {16'd0, mem_addr},     32'h0010);
        check("rd_we",       {31'd0, mem_we},       32'd0);
        step();
        check("rd_wait_en",  {31'd0, mem_en},       32'd1);
        check("rd_wait_rdy", {31'd0, memory_ready}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0;
        check("rd_data",     {16'd0, rd_data},      32'h1234);
        check("rd_done_en",  {31'd0, mem_en},       32'd0);
        check("rd_done_rdy", {31'd0, memory_ready}, 32'd0);
        step();
        check("rd_ready_hi", {31'd0, memory_ready}, 32'd1);

        // Push-style write: SR-1 wraps, IMM data.
        sr = 16'h0000; addr_sel = 2'd1; data_sel = 2'd3; imm = 16'hBEEF; req_wr = 1'b1;
        step();
        req_wr = 1'b0;
        check("wr_addr",  {16'd0, mem_addr},  32'hFFFF);
        check("wr_wdata", {16'd0, mem_wdata}, 32'hBEEF);
        check("wr_we",    {31'd0, mem_we},    32'd1);
        mem_ack = 1'b1; step(); mem_ack = 1'b0; step();
        check("wr_rd_kept", {16'd0, rd_data}, 32'h1234);

        // PC+1 wraps to zero.
        pc = 16'hFFFF; data_sel = 2'd1; addr_sel = 2'd2; req_wr = 1'b1;
        step();
        req_wr = 1'b0;
        check("pc1_wdata", {16'd0, mem_wdata}, 32'h0000);
        check("pc1_addr",  {16'd0, mem_addr},  32'hFFFF);
        mem_ack = 1'b1; step(); mem_ack = 1'b0; step();

        // Fetch then latch into IR.
        quick_read(16'h8C05, 1'b0);
        cmd_w = 1'b1; step(); cmd_w = 1'b0;
        check("fetch_opc", {26'd0, opcode}, 32'h23);
        // cmd_w on the ack cycle keeps the previous word.
        quick_read(16'h0400, 1'b1);
        check("ack_cmd_opc", {26'd0, opcode}, 32'h23);
        check("ack_cmd_rd",  {16'd0, rd_data}, 32'h0400);
        cmd_w = 1'b1; step(); cmd_w = 1'b0;
        check("late_cmd_opc", {26'd0, opcode}, 32'h01);

        // Simultaneous requests: single write.
        alu_out = 16'hA5A5; data_sel = 2'd2; r1 = 16'h0042; addr_sel = 2'd3;
        req_rd = 1'b1; req_wr = 1'b1;
        step();
        req_rd = 1'b0; req_wr = 1'b0;
        check("col_we",    {31'd0, mem_we},    32'd1);
        check("col_addr",  {16'd0, mem_addr},  32'h0042);
        check("col_wdata", {16'd0, mem_wdata}, 32'hA5A5);
        check("col_err0",  {31'd0, error},     32'd0);
        // Request during ACCESS flags error, transaction continues.
        req_rd = 1'b1; step(); req_rd = 1'b0;
        check("busy_err", {31'd0, error},  32'd1);
        check("busy_en",  {31'd0, mem_en}, 32'd1);
        check("busy_we",  {31'd0, mem_we}, 32'd1);
        mem_ack = 1'b1; step(); mem_ack = 1'b0; step();
        check("busy_ready", {31'd0, memory_ready}, 32'd1);
        check("busy_rd",    {16'd0, rd_data},      32'h0400);

        // Asynchronous reset during ACCESS with pending ack.
        sr = 16'h0077; addr_sel = 2'd0; req_rd = 1'b1;
        step();
        req_rd = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        #2 rst_n = 1'b0;
        #1;
        check("arst_en",    {31'd0, mem_en},       32'd0);
        check("arst_ready", {31'd0, memory_ready}, 32'd1);
        check("arst_err",   {31'd0, error},        32'd0);
        check("arst_rd",    {16'd0, rd_data},      32'h0);
        check("arst_addr",  {16'd0, mem_addr},     32'h0);
        check("arst_opc",   {26'd0, opcode},       32'h0);
        step();
        check("arst_hold_rd", {16'd0, rd_data}, 32'h0);
        mem_ack = 1'b0; rst_n = 1'b1;
        step();
        quick_read(16'h5A5A, 1'b0);
        check("post_rst_rd",  {16'd0, rd_data},      32'h5A5A);
        check("post_rst_rdy", {31'd0, memory_ready}, 32'd1);

        // Timeout: ERR on edge N+TO.
        req_rd = 1'b1; step(); req_rd = 1'b0;   // edge N
        step(); step(); step();                  // N+3
        check("to_err_early", {31'd0, error},  32'd0);
        check("to_en_early",  {31'd0, mem_en}, 32'd1);
        step();                                  // N+4
        check("to_err",   {31'd0, error},        32'd1);
        check("to_ready", {31'd0, memory_ready}, 32'd0);
        check("to_en",    {31'd0, mem_en},       32'd0);
        mem_ack = 1'b1; mem_rdata = 16'h7777; step(); mem_ack = 1'b0;
        step();
        check("to_late_ack_rd", {16'd0, rd_data},      32'h5A5A);
        check("to_stuck_ready", {31'd0, memory_ready}, 32'd0);
        check("to_stuck_en",    {31'd0, mem_en},       32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
